// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants and state encoding for the UART command responder
package uart_cmd_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] CMD_RD    = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    CSUM,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - shifts out up to 5 response bytes over the send/tx_busy handshake
module uart_tx_sequencer (
  input  logic        clk100,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [39:0] data_i,
  input  logic [2:0]  count_i,
  input  logic        tx_busy_i,
  output logic [7:0]  sbyte_o,
  output logic        send_o,
  output logic        idle_o
);

  logic [39:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sbyte_q, sbyte_d;
  logic        send_q, send_d;
  logic        fire;

  // The transmitter raises tx_busy one cycle after send, so the send_q guard
  // keeps us from issuing a second byte in that blind cycle.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    sbyte_d = sbyte_q;
    fire    = (cnt_q != 3'd0) && !tx_busy_i && !send_q;
    send_d  = fire;
    if (load_i) begin
      buf_d = data_i;
      cnt_d = count_i;
    end else if (fire) begin
      sbyte_d = buf_q[39:32];
      buf_d   = {buf_q[31:0], 8'h00};
      cnt_d   = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      sbyte_q <= '0;
      send_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      sbyte_q <= sbyte_d;
      send_q  <= send_d;
    end
  end

  assign sbyte_o = sbyte_q;
  assign send_o  = send_q;
  assign idle_o  = (cnt_q == 3'd0);

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - decodes UART command frames into a 4x32 register file and answers them
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int          TIMEOUT   = 2000000,
  parameter logic [31:0] REG0_INIT = 32'h0000_0000
) (
  input  logic         clk100,
  input  logic         reset_n,
  input  logic [7:0]   rx_byte,
  input  logic         rbyte_ready,
  input  logic         tx_busy,
  output logic [7:0]   sbyte,
  output logic         send,
  output logic [127:0] regs,
  output logic [3:0]   reg_wr,
  output logic         frame_err
);

  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  state_e                     state_q, state_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic                       is_wr_q, is_wr_d;
  logic [7:0]                 addr_q, addr_d;
  logic [7:0]                 csum_q, csum_d;
  logic [31:0]                buf_q, buf_d;
  logic [1:0]                 dcnt_q, dcnt_d;
  logic                       err_q, err_d;
  logic [NUM_REGS-1:0][31:0]  regs_q;

  logic                       in_frame;
  logic                       ld;
  logic [39:0]                ld_data;
  logic [2:0]                 ld_cnt;
  logic                       seq_idle;

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    csum_d    = csum_q;
    buf_d     = buf_q;
    dcnt_d    = dcnt_q;
    err_d     = err_q;
    ld        = 1'b0;
    ld_data   = '0;
    ld_cnt    = 3'd0;
    reg_wr    = 4'b0000;
    frame_err = 1'b0;
    in_frame  = (state_q == CMD) || (state_q == ADDR) ||
                (state_q == DATA) || (state_q == CSUM);

    case (state_q)
      IDLE: if (rbyte_ready && rx_byte == SYNC_BYTE) state_d = CMD;
      CMD: if (rbyte_ready) begin
        if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
          is_wr_d = (rx_byte == CMD_WR);
          csum_d  = rx_byte;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: if (rbyte_ready) begin
        addr_d  = rx_byte;
        csum_d  = csum_q ^ rx_byte;
        dcnt_d  = 2'd0;
        state_d = is_wr_q ? DATA : CSUM;
      end
      DATA: if (rbyte_ready) begin
        buf_d  = {buf_q[23:0], rx_byte};
        csum_d = csum_q ^ rx_byte;
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) state_d = CSUM;
      end
      CSUM: if (rbyte_ready) begin
        err_d   = (csum_q != rx_byte) || (addr_q >= 8'(NUM_REGS));
        state_d = EXEC;
      end
      EXEC: begin
        ld      = 1'b1;
        state_d = RESP;
        if (err_q) begin
          frame_err = 1'b1;
          ld_data   = {RSP_ERR, 32'h0};
          ld_cnt    = 3'd1;
        end else if (is_wr_q) begin
          reg_wr    = 4'b0001 << addr_q[1:0];
          ld_data   = {RSP_OK, 32'h0};
          ld_cnt    = 3'd1;
        end else begin
          ld_data   = {RSP_OK, regs_q[addr_q[1:0]]};
          ld_cnt    = 3'd5;
        end
      end
      RESP: if (seq_idle) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A byte arriving in the expiry cycle keeps the frame alive.
    if (in_frame && !rbyte_ready && tmo_q == TMO_LAST) state_d = IDLE;

    if (rbyte_ready || !in_frame) tmo_d = '0;
    else if (tmo_q != TMO_LAST)   tmo_d = tmo_q + 1'b1;
    else                          tmo_d = tmo_q;
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      csum_q  <= '0;
      buf_q   <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
      regs_q  <= {96'h0, REG0_INIT};
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      buf_q   <= buf_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_wr[i]) regs_q[i] <= buf_q;
      end
    end
  end

  assign regs = regs_q;

  uart_tx_sequencer u_tx_seq (
    .clk100    (clk100),
    .reset_n   (reset_n),
    .load_i    (ld),
    .data_i    (ld_data),
    .count_i   (ld_cnt),
    .tx_busy_i (tx_busy),
    .sbyte_o   (sbyte),
    .send_o    (send),
    .idle_o    (seq_idle)
  );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - scoreboard bench for the UART command responder
module tb_uart_cmd_responder;

  localparam int          TIMEOUT   = 40;
  localparam logic [31:0] REG0_INIT = 32'hDEAD_BEEF;
  localparam int          BUSY_CYC  = 6;

  logic         clk100 = 1'b0;
  logic         reset_n;
  logic [7:0]   rx_byte;
  logic         rbyte_ready;
  logic         tx_busy;
  logic [7:0]   sbyte;
  logic         send;
  logic [127:0] regs;
  logic [3:0]   reg_wr;
  logic         frame_err;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  logic [3:0] post_wr;
  logic       post_err;
  logic [7:0] fb[$];
  logic [7:0] exp_q[$];
  logic [127:0] regs_exp;

  always #5 clk100 = ~clk100;

  uart_cmd_responder #(.TIMEOUT(TIMEOUT), .REG0_INIT(REG0_INIT)) dut (
    .clk100      (clk100),
    .reset_n     (reset_n),
    .rx_byte     (rx_byte),
    .rbyte_ready (rbyte_ready),
    .tx_busy     (tx_busy),
    .sbyte       (sbyte),
    .send        (send),
    .regs        (regs),
    .reg_wr      (reg_wr),
    .frame_err   (frame_err)
  );

  // UART transmitter model: busy starts the cycle after send.
  always @(posedge clk100) begin
    if (send)              busy_cnt <= BUSY_CYC;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk100) begin
    if (reset_n) begin
      if (reg_wr != 4'b0000) wr_cnt++;
      if (frame_err) err_cnt++;
      if (send) begin
        chk("send_while_busy", tx_busy, 1'b0);
        chk("send_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("sbyte", sbyte, exp_q.pop_front());
      end
    end
  end

  task automatic send_frame();
    foreach (fb[i]) begin
      @(negedge clk100);
      rx_byte     = fb[i];
      rbyte_ready = 1'b1;
      @(negedge clk100);
      rbyte_ready = 1'b0;
      post_wr     = reg_wr;
      post_err    = frame_err;
      repeat (3) @(negedge clk100);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk100);
    chk("drain", exp_q.size(), 0);
    repeat (30) @(negedge clk100);
  endtask

  initial begin
    reset_n     = 1'b0;
    rbyte_ready = 1'b0;
    rx_byte     = 8'h00;
    repeat (3) @(negedge clk100);
    regs_exp = {96'h0, REG0_INIT};
    chk("rst_regs", regs, regs_exp);
    chk("rst_send", send, 1'b0);
    chk("rst_sbyte", sbyte, 8'h00);
    chk("rst_reg_wr", reg_wr, 4'b0000);
    chk("rst_frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk100);

    // good write to reg1
    fb = '{8'hA5, 8'h57, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h5E};
    exp_q.push_back(8'h4B);
    send_frame();
    chk("wr1_strobe", post_wr, 4'b0010);
    chk("wr1_err", post_err, 1'b0);
    drain();
    regs_exp[63:32] = 32'h1234_5678;
    chk("wr1_regs", regs, regs_exp);
    chk("wr1_count", wr_cnt, 1);

    // read back reg1
    fb = '{8'hA5, 8'h52, 8'h01, 8'h53};
    exp_q.push_back(8'h4B); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    send_frame();
    chk("rd1_strobe", post_wr, 4'b0000);
    drain();

    // checksum error on write
    fb = '{8'hA5, 8'h57, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    exp_q.push_back(8'h45);
    send_frame();
    chk("csum_err_pulse", post_err, 1'b1);
    drain();
    chk("csum_err_regs", regs, regs_exp);
    chk("csum_err_wrcnt", wr_cnt, 1);

    // bad address
    fb = '{8'hA5, 8'h52, 8'h07, 8'h55};
    exp_q.push_back(8'h45);
    send_frame();
    chk("addr_err_pulse", post_err, 1'b1);
    drain();
    chk("err_count", err_cnt, 2);

    // partial frame abandoned by timeout, then read reg0
    fb = '{8'hA5, 8'h57, 8'h00, 8'h12};
    send_frame();
    repeat (TIMEOUT + 5) @(negedge clk100);
    fb = '{8'hA5, 8'h52, 8'h00, 8'h52};
    exp_q.push_back(8'h4B); exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    send_frame();
    drain();
    chk("tmo_wrcnt", wr_cnt, 1);
    chk("tmo_regs", regs, regs_exp);

    // garbage and an invalid command, then a valid write to reg3
    fb = '{8'h00, 8'hFF, 8'hA5, 8'h41};
    send_frame();
    repeat (20) @(negedge clk100);
    fb = '{8'hA5, 8'h57, 8'h03, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h9D};
    exp_q.push_back(8'h4B);
    send_frame();
    chk("wr3_strobe", post_wr, 4'b1000);
    drain();
    regs_exp[127:96] = 32'hCAFE_F00D;
    chk("wr3_regs", regs, regs_exp);

    // sync byte inside the payload is plain data
    fb = '{8'hA5, 8'h57, 8'h02, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h54};
    exp_q.push_back(8'h4B);
    send_frame();
    drain();
    regs_exp[95:64] = 32'hA5A5_0001;
    chk("wr2_regs", regs, regs_exp);
    chk("wr_count", wr_cnt, 3);

    // reset after the second reply byte of a read
    fb = '{8'hA5, 8'h52, 8'h03, 8'h51};
    exp_q.push_back(8'h4B); exp_q.push_back(8'hCA);
    send_frame();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk100);
    chk("mid_rsp_sent", exp_q.size(), 0);
    reset_n = 1'b0;
    #1;
    regs_exp = {96'h0, REG0_INIT};
    chk("mid_rsp_send", send, 1'b0);
    chk("mid_rsp_regs", regs, regs_exp);
    chk("mid_rsp_sbyte", sbyte, 8'h00);
    repeat (3) @(negedge clk100);
    reset_n = 1'b1;
    repeat (200) @(negedge clk100);
    chk("post_rst_regs", regs, regs_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
